// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with a per-register pending-write scoreboard.
// Optional write-through forwarding on the read ports: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  localparam logic ZR = (ZERO_REG != 0);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             iss_fire;
  logic             wr_ok;

  // Writes to a hardwired-zero register 0 are dropped entirely.
  assign wr_ok    = we && !(ZR && (wa == '0));
  assign iss_ready = rst & ~busy[iss_rd];
  assign iss_fire  = iss_valid & iss_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  // A new producer claiming the register wins over a same-cycle writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (ZR && (r == 0))
          busy[r] <= 1'b0;
        else if (iss_fire && (iss_rd == AW'(r)))
          busy[r] <= 1'b1;
        else if (we && (wa == AW'(r)))
          busy[r] <= 1'b0;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic hit1, hit2;
  assign hit1 = wr_ok && (wa == rs1_addr);
  assign hit2 = wr_ok && (wa == rs2_addr);

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (rst) begin
      rs1_data = hit1 ? wd : regs[rs1_addr];
      rs2_data = hit2 ? wd : regs[rs2_addr];
      rs1_busy = busy[rs1_addr] & ~hit1;
      rs2_busy = busy[rs2_addr] & ~hit2;
    end
  end
`else
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (rst) begin
      rs1_data = regs[rs1_addr];
      rs2_data = regs[rs2_addr];
      rs1_busy = busy[rs1_addr];
      rs2_busy = busy[rs2_addr];
    end
  end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default 32x32 instance plus a
// 64-bit, 16-entry instance with an ordinary register 0.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs1Addr = '0, rs2Addr = '0, issRd = '0, wa = '0;
  logic [31:0] rs1Data, rs2Data, wd = '0;
  logic        rs1Busy, rs2Busy, issValid = 1'b0, issReady, we = 1'b0;

  logic [3:0]  bRs1Addr = '0, bRs2Addr = '0, bIssRd = '0, bWa = '0;
  logic [63:0] bRs1Data, bRs2Data, bWd = '0;
  logic        bRs1Busy, bRs2Busy, bIssValid = 1'b0, bIssReady, bWe = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [63:0] expQ [$];

  always #5 clk = ~clk;

  regfile_scoreboard dutA (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1Addr), .rs2_addr(rs2Addr),
    .rs1_data(rs1Data), .rs2_data(rs2Data),
    .rs1_busy(rs1Busy), .rs2_busy(rs2Busy),
    .iss_valid(issValid), .iss_rd(issRd), .iss_ready(issReady),
    .we(we), .wa(wa), .wd(wd)
  );

  regfile_scoreboard #(.XLEN(64), .NREGS(16), .ZERO_REG(0)) dutB (
    .clk(clk), .rst(rst),
    .rs1_addr(bRs1Addr), .rs2_addr(bRs2Addr),
    .rs1_data(bRs1Data), .rs2_data(bRs2Data),
    .rs1_busy(bRs1Busy), .rs2_busy(bRs2Busy),
    .iss_valid(bIssValid), .iss_rd(bIssRd), .iss_ready(bIssReady),
    .we(bWe), .wa(bWa), .wd(bWd)
  );

  task automatic pushExpected(input logic [63:0] v);
    expQ.push_back(v);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp = expQ.pop_front();
      assert (obs === exp) else begin
        bad++;
        $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d,
                               input logic iv, input logic [4:0] rd);
    we = w; wa = a; wd = d; issValid = iv; issRd = rd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Held in reset from time zero.
    #2;
    pushExpected(0); checkOutput("rst_ready", 64'(issReady));
    pushExpected(0); checkOutput("rst_rs1", 64'(rs1Data));
    pushExpected(0); checkOutput("rst_busy", 64'(rs1Busy));
    tick; tick;
    rst = 1'b1; #1;
    pushExpected(1); checkOutput("ready_after_rst", 64'(issReady));

    // Write/read and the hardwired zero register.
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0); tick;
    applyStimulus(0, 0, 0, 0, 0); rs1Addr = 5; #1;
    pushExpected(32'hDEADBEEF); checkOutput("rd_reg5", 64'(rs1Data));
    applyStimulus(1, 0, 32'h1, 0, 0); tick;
    applyStimulus(0, 0, 0, 0, 0); rs1Addr = 0; #1;
    pushExpected(0); checkOutput("rd_reg0", 64'(rs1Data));

    // Issue marks rd=7 pending; writeback clears it.
    applyStimulus(0, 0, 0, 1, 7); rs2Addr = 7; #1;
    pushExpected(1); checkOutput("ready_rd7_free", 64'(issReady));
    tick;
    applyStimulus(0, 0, 0, 0, 7); #1;
    pushExpected(1); checkOutput("busy_rd7", 64'(rs2Busy));
    pushExpected(0); checkOutput("ready_rd7_busy", 64'(issReady));
    applyStimulus(1, 7, 32'h55, 0, 7); #1;
    pushExpected(BYP ? 32'h55 : 32'h0); checkOutput("wb_rd7_data_same", 64'(rs2Data));
    pushExpected(BYP ? 0 : 1); checkOutput("wb_rd7_busy_same", 64'(rs2Busy));
    tick;
    applyStimulus(0, 0, 0, 0, 7); #1;
    pushExpected(0); checkOutput("busy_rd7_cleared", 64'(rs2Busy));
    pushExpected(32'h55); checkOutput("data_rd7", 64'(rs2Data));
    pushExpected(1); checkOutput("ready_rd7_again", 64'(issReady));

    // Accepted issue and writeback to the same register: the issue wins.
    rs1Addr = 3;
    applyStimulus(1, 3, 32'h33, 1, 3); tick;
    applyStimulus(0, 0, 0, 0, 3); #1;
    pushExpected(1); checkOutput("simul_busy3", 64'(rs1Busy));
    pushExpected(32'h33); checkOutput("simul_data3", 64'(rs1Data));
    // Busy reg: issue is refused, so the writeback alone clears it.
    applyStimulus(1, 3, 32'h44, 1, 3); #1;
    pushExpected(0); checkOutput("busy3_ready", 64'(issReady));
    tick;
    applyStimulus(0, 0, 0, 0, 0); #1;
    pushExpected(0); checkOutput("busy3_cleared", 64'(rs1Busy));
    pushExpected(32'h44); checkOutput("data3_new", 64'(rs1Data));

    // Same-cycle read of a register being written.
    applyStimulus(1, 9, 32'h11, 0, 0); tick;
    applyStimulus(1, 9, 32'hA5A5A5A5, 0, 0); rs1Addr = 9; #1;
    pushExpected(BYP ? 32'hA5A5A5A5 : 32'h11); checkOutput("bypass_data", 64'(rs1Data));
    pushExpected(0); checkOutput("bypass_busy", 64'(rs1Busy));
    tick;
    applyStimulus(0, 0, 0, 0, 0); #1;
    pushExpected(32'hA5A5A5A5); checkOutput("after_wr9", 64'(rs1Data));

    // Mid-run reset with a pending register outstanding.
    applyStimulus(0, 0, 0, 1, 12); tick;
    applyStimulus(0, 0, 0, 0, 12); rs1Addr = 5; rs2Addr = 12; #1;
    pushExpected(1); checkOutput("busy12_pre", 64'(rs2Busy));
    rst = 1'b0; #1;
    pushExpected(0); checkOutput("midrst_data5", 64'(rs1Data));
    pushExpected(0); checkOutput("midrst_busy12", 64'(rs2Busy));
    pushExpected(0); checkOutput("midrst_ready", 64'(issReady));
    tick;
    rst = 1'b1; #1;
    for (int r = 0; r < 32; r++) begin
      rs1Addr = 5'(r); rs2Addr = 5'(31 - r); #1;
      pushExpected(0); checkOutput("postrst_rs1", 64'(rs1Data));
      pushExpected(0); checkOutput("postrst_rs2", 64'(rs2Data));
    end
    rs2Addr = 12;
    pushExpected(0); checkOutput("postrst_busy12", 64'(rs2Busy));
    applyStimulus(1, 12, 32'h12, 0, 0); tick;
    applyStimulus(0, 0, 0, 0, 0); #1;
    pushExpected(32'h12); checkOutput("plain_wr12", 64'(rs2Data));
    pushExpected(0); checkOutput("plain_busy12", 64'(rs2Busy));

    // Wide instance: register 0 is ordinary, writable and trackable.
    bWe = 1; bWa = 0; bWd = 64'hFFFF_0000_1234_5678; tick;
    bWe = 0; bRs1Addr = 0; #1;
    pushExpected(64'hFFFF_0000_1234_5678); checkOutput("b_reg0_data", bRs1Data);
    bIssValid = 1; bIssRd = 0; tick;
    bIssValid = 0; #1;
    pushExpected(1); checkOutput("b_reg0_busy", 64'(bRs1Busy));
    pushExpected(0); checkOutput("b_reg0_ready", 64'(bIssReady));
    bWe = 1; bWa = 0; bWd = 64'h0123_4567_89AB_CDEF; tick;
    bWe = 0; bRs2Addr = 0; #1;
    pushExpected(0); checkOutput("b_reg0_cleared", 64'(bRs2Busy));
    pushExpected(64'h0123_4567_89AB_CDEF); checkOutput("b_reg0_new", bRs2Data);
    bWe = 1; bWa = 15; bWd = 64'h8000_0000_0000_0001; tick;
    bWe = 0; bRs1Addr = 15; #1;
    pushExpected(64'h8000_0000_0000_0001); checkOutput("b_reg15", bRs1Data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
